io_input_conditioner: RTL

Conditions raw board switches and push-buttons before they reach the LSU's memory-mapped input region.
- Two-stage synchronizer per bit.
- Debounce using a shared tick prescaler.
- Active-low button normalization.
- One-cycle press/release pulses.

Outputs drive the LSU's 32-bit i_io_sw and i_io_btn inputs directly. The block sits between the FPGA pins and the LSU.

---
 rtl/io_pkg.sv | 21 ++
 rtl/io_debounce_cell.sv | 61 ++++++
 rtl/io_input_conditioner.sv | 101 ++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared constants for the board input conditioner: default geometry, debounce timing,
// LSU input-region byte offsets and the debounce counter width helper.
package io_pkg;

    localparam int SW_W_DEF         = 18;
    localparam int BTN_W_DEF        = 4;
    localparam int TICK_CYC_DEF     = 50000;
    localparam int STABLE_TICKS_DEF = 10;

    // Byte offsets of the conditioned words inside the LSU memory-mapped input region
    localparam logic [7:0] IO_SW_OFFSET  = 8'h00;
    localparam logic [7:0] IO_BTN_OFFSET = 8'h10;

    // Counter must hold 0..stable_ticks
    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(STABLE_TICKS_DEF);

endpackage

// File: rtl/io_debounce_cell.sv
// One input bit: synchronizer, tick-driven debounce counter, stable level and edge pulses.
// Latency SYNC_STAGES edges to synced, then (STABLE_TICKS-1)*tick+1 .. STABLE_TICKS*tick edges; no backpressure.
module io_debounce_cell
    import io_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam int               CNT_W    = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   stable_q;
    logic                   rise_q;
    logic                   fall_q;
    logic [CNT_W-1:0]       cnt_q;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            // Any agreement, even for a single cycle, discards the partial count
            if (synced == stable_q) begin
                cnt_q <= '0;
            end else if (i_tick) begin
                if (cnt_q == CNT_LAST) begin
                    stable_q <= synced;
                    rise_q   <= synced;
                    fall_q   <= ~synced;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign o_stable = stable_q;
    assign o_rise   = rise_q;
    assign o_fall   = fall_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Conditions raw switches/buttons for the LSU input region: shared tick prescaler, button polarity fix, zero-extension.
// Latency SYNC_STAGES + up to STABLE_TICKS*TICK_CYC edges per accepted change; no backpressure (pins are free-running).
module io_input_conditioner
    import io_pkg::*;
#(
    parameter int SW_W           = SW_W_DEF,
    parameter int BTN_W          = BTN_W_DEF,
    parameter int SYNC_STAGES    = 2,
    parameter int TICK_CYC       = TICK_CYC_DEF,
    parameter int STABLE_TICKS   = STABLE_TICKS_DEF,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [SW_W-1:0]   i_sw_raw,
    input  logic [BTN_W-1:0]  i_btn_raw,
    output logic [31:0]       o_io_sw,
    output logic [31:0]       o_io_btn,
    output logic [BTN_W-1:0]  o_btn_press,
    output logic [BTN_W-1:0]  o_btn_release,
    output logic              o_tick
);

    localparam int               PRE_W    = $clog2(TICK_CYC);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYC - 1);
    localparam logic             BTN_INV  = (BTN_ACTIVE_LOW != 0);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             tick;

    logic [BTN_W-1:0] btn_n;
    logic [SW_W-1:0]  sw_stable;
    logic [SW_W-1:0]  sw_rise;
    logic [SW_W-1:0]  sw_fall;
    logic [BTN_W-1:0] btn_stable;
    logic             unused_sw_edges;

    assign tick = (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        if (tick) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // Normalize before synchronizing so a cleared flop always means "released"
    assign btn_n = i_btn_raw ^ {BTN_W{BTN_INV}};

    for (genvar g = 0; g < SW_W; g++) begin : gen_sw
        io_debounce_cell #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS)
        ) u_cell (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_raw    (i_sw_raw[g]),
            .i_tick   (tick),
            .o_stable (sw_stable[g]),
            .o_rise   (sw_rise[g]),
            .o_fall   (sw_fall[g])
        );
    end

    for (genvar g = 0; g < BTN_W; g++) begin : gen_btn
        io_debounce_cell #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS)
        ) u_cell (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_raw    (btn_n[g]),
            .i_tick   (tick),
            .o_stable (btn_stable[g]),
            .o_rise   (o_btn_press[g]),
            .o_fall   (o_btn_release[g])
        );
    end

    // Switches expose levels only; their edge pulses are intentionally dropped
    assign unused_sw_edges = ^{sw_rise, sw_fall};

    always_comb begin
        o_io_sw              = '0;
        o_io_sw[SW_W-1:0]    = sw_stable;
        o_io_btn             = '0;
        o_io_btn[BTN_W-1:0]  = btn_stable;
    end

    assign o_tick = tick;

endmodule
